pe_mac_param: RTL
=================

PE_MAC_PARAM -- requirements
Module: pe_mac_param

Interface
REQ-001 Parameter DATA_W, default 8: west/east operand and weight width in bits.
REQ-002 Parameter ACC_W, default 32: north/south partial-sum width; SHALL be >= 2*DATA_W.
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement operands; 0 = unsigned.
REQ-004 Parameter SATURATE, default 0: 1 = clamp sums to the ACC_W range; 0 = wrap modulo 2^ACC_W.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 i_wload  input  1  writes i_weight into the shadow weight register.
REQ-008 i_weight  input  DATA_W  shadow weight load data.
REQ-009 i_wswap  input  1  copies the shadow weight into the active weight.
REQ-010 i_valid  input  1  i_west/i_north carry a valid operand this cycle.
REQ-011 i_west  input  DATA_W  activation operand.
REQ-012 i_north  input  ACC_W  incoming partial sum.
REQ-013 i_clr_ovf  input  1  clears the sticky overflow flag.
REQ-014 o_east  output  DATA_W  registered activation forwarded east.
REQ-015 o_south  output  ACC_W  registered partial sum forwarded south.
REQ-016 o_valid  output  1  o_east/o_south valid; registered copy of i_valid.
REQ-017 o_weight  output  DATA_W  shadow weight, daisy-chained south for column weight loading.
REQ-018 o_ovf  output  1  sticky overflow/saturation flag.

Function
REQ-019 Two weight registers SHALL exist: shadow (loaded by i_wload) and active (used by the MAC); loads SHALL never disturb an in-flight computation.
REQ-020 i_wswap SHALL set active <= shadow at the edge; the MAC in that same cycle SHALL use the pre-swap active weight.
REQ-021 i_wload and i_wswap together: active <= old shadow, shadow <= i_weight.
REQ-022 o_weight SHALL equal the shadow register (latency 1 from i_wload).
REQ-023 When i_valid=1: o_east <= i_west; o_south <= f(i_north + ext(i_west*active)); o_valid <= 1; latency exactly 1 cycle.
REQ-024 When i_valid=0: o_east and o_south SHALL hold their values; o_valid <= 0.
REQ-025 Product SHALL be computed at 2*DATA_W bits, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W before addition.
REQ-026 Overflow: the exact sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1] (signed) or outside [0, 2^ACC_W-1] (unsigned).
REQ-027 On overflow with SATURATE=1, o_south SHALL be the nearest range bound; with SATURATE=0, the low ACC_W bits of the sum.
REQ-028 Any overflow on a valid cycle SHALL set o_ovf at the following edge, in either mode.
REQ-029 o_ovf SHALL remain set until i_clr_ovf=1 or reset; overflow and i_clr_ovf in the same cycle SHALL leave o_ovf=1.
REQ-030 i_wload, i_wswap and i_clr_ovf SHALL act independently of i_valid.

Reset
REQ-031 reset=0 at an edge SHALL clear shadow, active, o_east, o_south, o_valid, o_ovf and o_weight to 0, overriding all other inputs.
REQ-032 Reset asserted mid-stream SHALL discard the in-flight operand; the first valid result after release SHALL use weight 0 until a new load and swap occur.

Verification
REQ-033 Defaults: load 3, swap, then i_valid=1, west=-2 (0xFE), north=10 -> next cycle o_south=4, o_east=0xFE, o_valid=1.
REQ-034 SIGNED=0, active=3, west=0xFE, north=10 -> o_south=772; i_valid=0 next cycle -> o_south holds 772, o_valid=0.
REQ-035 ACC_W=16, SIGNED=1, SATURATE=1, active=127, west=127, north=32767 -> o_south=32767 and o_ovf=1 one cycle later; o_ovf stays 1 until i_clr_ovf.
REQ-036 Same stimulus with SATURATE=0 -> o_south=-16640 (0xBF00), o_ovf=1.
REQ-037 Active=2, shadow=5; the same cycle drives i_wload=1 with i_weight=9, i_wswap=1, i_valid=1, west=1, north=0 -> o_south=2, then active=5, o_weight=9; the next valid cycle with west=1, north=0 -> o_south=5.
REQ-038 Streaming valid data, reset=0 for one cycle -> all outputs 0 at the next edge; after release, west=4, north=1 -> o_south=1.

Source files
------------

// File: rtl/pe_mac_param.sv
// rtl/pe_mac_param.sv - systolic-array MAC processing element with shadow weight and overflow handling
module pe_mac_param #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wload,
  input  logic [DATA_W-1:0] i_weight,
  input  logic              i_wswap,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_west,
  input  logic [ACC_W-1:0]  i_north,
  input  logic              i_clr_ovf,
  output logic [DATA_W-1:0] o_east,
  output logic [ACC_W-1:0]  o_south,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_weight,
  output logic              o_ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int EW = ACC_W + 1 - PW;

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] east_q, east_d;
  logic [ACC_W-1:0]  south_q, south_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     west_x, wgt_x, prod;
  logic              prod_sgn, north_sgn;
  logic [ACC_W:0]    sum_x;
  logic              ovf_now;
  logic [ACC_W-1:0]  sum_f;

  // Arithmetic: full-width product, then an ACC_W+1 bit exact sum so overflow is visible
  always_comb begin
    west_x = {{DATA_W{(SIGNED != 0) & i_west[DATA_W-1]}}, i_west};
    wgt_x  = {{DATA_W{(SIGNED != 0) & active_q[DATA_W-1]}}, active_q};
    // Low PW bits of the product are identical for signed and unsigned operands
    prod      = west_x * wgt_x;
    prod_sgn  = (SIGNED != 0) & prod[PW-1];
    north_sgn = (SIGNED != 0) & i_north[ACC_W-1];
    sum_x     = {north_sgn, i_north} + {{EW{prod_sgn}}, prod};
    if (SIGNED != 0) begin
      ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    end else begin
      ovf_now = sum_x[ACC_W];
    end
    sum_f = sum_x[ACC_W-1:0];
    if ((SATURATE != 0) && ovf_now) begin
      if (SIGNED != 0) begin
        // The extra top bit holds the true sign of the exact sum
        sum_f = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_f = {ACC_W{1'b1}};
      end
    end
  end

  // Next-state: weight double buffering, data forwarding and sticky overflow
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    east_d   = east_q;
    south_d  = south_q;
    valid_d  = i_valid;
    ovf_d    = ovf_q;
    if (i_wload) shadow_d = i_weight;
    // Swap takes the pre-load shadow so a simultaneous load lands one slot behind
    if (i_wswap) active_d = shadow_q;
    if (i_valid) begin
      east_d  = i_west;
      south_d = sum_f;
    end
    // A fresh overflow wins over a clear in the same cycle
    if (i_valid && ovf_now) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
      east_q   <= '0;
      south_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      east_q   <= east_d;
      south_q  <= south_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_east   = east_q;
  assign o_south  = south_q;
  assign o_valid  = valid_q;
  assign o_weight = shadow_q;
  assign o_ovf    = ovf_q;

endmodule
